// File: rtl/sao_stat_accum.sv
// sao_stat_accum: accumulates per-2x2-block SAO statistics into per-CTU
// totals for edge-offset (EO) and, optionally, band-offset (BO) classes.
//
// A CTU is opened by en_i&first_i, which loads every accumulator with that
// block's values. It is closed by en_i&last_i. One cycle after the closing
// block, en_o pulses and the outputs hold the final totals. They stay stable
// until the next en_i&first_i. Sums saturate at the signed limits of their
// width and counts saturate at all-ones.
//
// Optional feature macro: SAO_BO_STAT_EN. When it is defined, the BO
// accumulators are built. When it is undefined, the BO inputs are ignored
// and the BO outputs are tied to zero.
//
// Ports
//   clk, arst_n            clock, asynchronous active-low reset
//   en_i, first_i, last_i  block valid, first block of CTU, last block of CTU
//   blk_sum_i/blk_num_i    EO block difference sums / pixel counts
//   blk_sum_bo_i/_num_bo_i BO block difference sums / pixel counts
//   sum_blk_CTU/num_blk_CTU       EO CTU totals
//   sum_blk_CTU_bo/num_blk_CTU_bo BO CTU totals
//   en_o                   one-cycle pulse: CTU totals valid
module sao_stat_accum #(
  parameter int diff_clip_bit    = 4,
  parameter int num_pix_CTU_log2 = 5,
  parameter int n_eo_type        = 4,
  parameter int n_category       = 4,
  parameter int n_category_bo    = 8,
  localparam int num_accu_len    = num_pix_CTU_log2*2-1
) (
  input  logic                                     clk,
  input  logic                                     arst_n,
  input  logic                                     en_i,
  input  logic                                     first_i,
  input  logic                                     last_i,
  input  logic signed [diff_clip_bit+2:0]          blk_sum_i       [n_eo_type][n_category],
  input  logic        [2:0]                        blk_num_i       [n_eo_type][n_category],
  input  logic signed [diff_clip_bit+2:0]          blk_sum_bo_i    [n_category_bo],
  input  logic        [2:0]                        blk_num_bo_i    [n_category_bo],
  output logic signed [num_accu_len+diff_clip_bit:0] sum_blk_CTU   [n_eo_type][n_category],
  output logic        [num_accu_len:0]             num_blk_CTU     [n_eo_type][n_category],
  output logic signed [num_accu_len+diff_clip_bit:0] sum_blk_CTU_bo [n_category_bo],
  output logic        [num_accu_len:0]             num_blk_CTU_bo  [n_category_bo],
  output logic                                     en_o
);

  localparam int IW = diff_clip_bit + 3;
  localparam int SW = num_accu_len + diff_clip_bit + 1;
  localparam int CW = num_accu_len + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  state_e state_q, state_d;
  logic   en_o_q, en_o_d;
  logic   load, add;

  logic signed [SW-1:0] sum_q [n_eo_type][n_category];
  logic signed [SW-1:0] sum_d [n_eo_type][n_category];
  logic        [CW-1:0] num_q [n_eo_type][n_category];
  logic        [CW-1:0] num_d [n_eo_type][n_category];

  // One guard bit catches overflow. A disagreement between the guard bit and
  // the MSB selects the signed limit.
  function automatic logic signed [SW-1:0] sat_sum(input logic signed [SW-1:0] acc,
                                                   input logic signed [IW-1:0] blk);
    logic [SW:0] s;
    s = {acc[SW-1], acc} + {{(SW+1-IW){blk[IW-1]}}, blk};
    if (s[SW] != s[SW-1])
      sat_sum = s[SW] ? {1'b1, {(SW-1){1'b0}}} : {1'b0, {(SW-1){1'b1}}};
    else
      sat_sum = s[SW-1:0];
  endfunction

  function automatic logic [CW-1:0] sat_cnt(input logic [CW-1:0] acc,
                                            input logic [2:0]    blk);
    logic [CW:0] s;
    s = {1'b0, acc} + {{(CW-2){1'b0}}, blk};
    sat_cnt = s[CW] ? '1 : s[CW-1:0];
  endfunction

  // first_i restarts from any state. Plain blocks only count inside a CTU.
  assign load = en_i & first_i;
  assign add  = en_i & ~first_i & (state_q == ACCUM);

  always_comb begin
    state_d = state_q;
    en_o_d  = (load | add) & last_i;
    if (load) begin
      state_d = last_i ? DONE : ACCUM;
    end else begin
      case (state_q)
        ACCUM:   if (en_i && last_i) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < n_eo_type; i++) begin
      for (int unsigned j = 0; j < n_category; j++) begin
        sum_d[i][j] = sum_q[i][j];
        num_d[i][j] = num_q[i][j];
        if (load) begin
          sum_d[i][j] = sat_sum('0, blk_sum_i[i][j]);
          num_d[i][j] = sat_cnt('0, blk_num_i[i][j]);
        end else if (add) begin
          sum_d[i][j] = sat_sum(sum_q[i][j], blk_sum_i[i][j]);
          num_d[i][j] = sat_cnt(num_q[i][j], blk_num_i[i][j]);
        end
      end
    end
  end

`ifdef SAO_BO_STAT_EN
  logic signed [SW-1:0] sum_bo_q [n_category_bo];
  logic signed [SW-1:0] sum_bo_d [n_category_bo];
  logic        [CW-1:0] num_bo_q [n_category_bo];
  logic        [CW-1:0] num_bo_d [n_category_bo];

  always_comb begin
    for (int unsigned k = 0; k < n_category_bo; k++) begin
      sum_bo_d[k] = sum_bo_q[k];
      num_bo_d[k] = num_bo_q[k];
      if (load) begin
        sum_bo_d[k] = sat_sum('0, blk_sum_bo_i[k]);
        num_bo_d[k] = sat_cnt('0, blk_num_bo_i[k]);
      end else if (add) begin
        sum_bo_d[k] = sat_sum(sum_bo_q[k], blk_sum_bo_i[k]);
        num_bo_d[k] = sat_cnt(num_bo_q[k], blk_num_bo_i[k]);
      end
    end
  end

  assign sum_blk_CTU_bo = sum_bo_q;
  assign num_blk_CTU_bo = num_bo_q;
`else
  logic unused_bo;

  always_comb begin
    unused_bo = 1'b0;
    for (int unsigned k = 0; k < n_category_bo; k++)
      unused_bo = unused_bo ^ (^blk_sum_bo_i[k]) ^ (^blk_num_bo_i[k]);
  end

  assign sum_blk_CTU_bo = '{default: '0};
  assign num_blk_CTU_bo = '{default: '0};
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= IDLE;
      en_o_q   <= 1'b0;
      sum_q    <= '{default: '0};
      num_q    <= '{default: '0};
`ifdef SAO_BO_STAT_EN
      sum_bo_q <= '{default: '0};
      num_bo_q <= '{default: '0};
`endif
    end else begin
      state_q  <= state_d;
      en_o_q   <= en_o_d;
      sum_q    <= sum_d;
      num_q    <= num_d;
`ifdef SAO_BO_STAT_EN
      sum_bo_q <= sum_bo_d;
      num_bo_q <= num_bo_d;
`endif
    end
  end

  assign sum_blk_CTU = sum_q;
  assign num_blk_CTU = num_q;
  assign en_o        = en_o_q;

endmodule

// File: tb/tb_sao_stat_accum.sv
module tb_sao_stat_accum;

  localparam int NE  = 4;
  localparam int NC  = 4;
  localparam int NB  = 8;
`ifdef SAO_BO_STAT_EN
  localparam bit BO_ON = 1'b1;
`else
  localparam bit BO_ON = 1'b0;
`endif

  logic clk, arst_n, en_i, first_i, last_i, en_o;
  logic signed [6:0]  blk_sum_i      [NE][NC];
  logic        [2:0]  blk_num_i      [NE][NC];
  logic signed [6:0]  blk_sum_bo_i   [NB];
  logic        [2:0]  blk_num_bo_i   [NB];
  logic signed [13:0] sum_blk_CTU    [NE][NC];
  logic        [9:0]  num_blk_CTU    [NE][NC];
  logic signed [13:0] sum_blk_CTU_bo [NB];
  logic        [9:0]  num_blk_CTU_bo [NB];

  sao_stat_accum #(
    .diff_clip_bit(4), .num_pix_CTU_log2(5), .n_eo_type(NE), .n_category(NC), .n_category_bo(NB)
  ) dut (
    .clk(clk), .arst_n(arst_n), .en_i(en_i), .first_i(first_i), .last_i(last_i),
    .blk_sum_i(blk_sum_i), .blk_num_i(blk_num_i),
    .blk_sum_bo_i(blk_sum_bo_i), .blk_num_bo_i(blk_num_bo_i),
    .sum_blk_CTU(sum_blk_CTU), .num_blk_CTU(num_blk_CTU),
    .sum_blk_CTU_bo(sum_blk_CTU_bo), .num_blk_CTU_bo(num_blk_CTU_bo),
    .en_o(en_o)
  );

  typedef struct {
    int s  [NE][NC];
    int n  [NE][NC];
    int sb [NB];
    int nb [NB];
    int cyc;
  } exp_t;

  exp_t e;
  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int i, input int j, input int act, input int expv);
    checks++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s[%0d][%0d]: got %0d, expected %0d (t=%0t)", nm, i, j, act, expv, $time);
    end
  endtask

  // Scoreboard monitor: every en_o pulse must match the oldest expected CTU.
  always @(negedge clk) begin
    exp_t x;
    if (en_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL en_o_unexpected: got en_o=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        x = exp_q.pop_front();
        chk("en_o_cycle", 0, 0, cyc, x.cyc);
        for (int i = 0; i < NE; i++)
          for (int j = 0; j < NC; j++) begin
            chk("eo_sum", i, j, int'(sum_blk_CTU[i][j]), x.s[i][j]);
            chk("eo_num", i, j, int'(num_blk_CTU[i][j]), x.n[i][j]);
          end
        for (int k = 0; k < NB; k++) begin
          chk("bo_sum", k, 0, int'(sum_blk_CTU_bo[k]), x.sb[k]);
          chk("bo_num", k, 0, int'(num_blk_CTU_bo[k]), x.nb[k]);
        end
      end
    end
  end

  task automatic set_bo();
    for (int k = 0; k < NB; k++) begin
      blk_sum_bo_i[k] = 7'sd7;
      blk_num_bo_i[k] = 3'd4;
    end
  endtask

  // Uniform block: every EO entry gets the same sum/count.
  task automatic send_u(input bit f, input bit l, input int s, input int n);
    @(negedge clk);
    for (int i = 0; i < NE; i++)
      for (int j = 0; j < NC; j++) begin
        blk_sum_i[i][j] = 7'(s);
        blk_num_i[i][j] = 3'(n);
      end
    set_bo();
    en_i = 1'b1; first_i = f; last_i = l;
  endtask

  // Single-entry block: only EO entry [a][b] is non-zero.
  task automatic send_1(input bit f, input bit l, input int a, input int b, input int s, input int n);
    @(negedge clk);
    for (int i = 0; i < NE; i++)
      for (int j = 0; j < NC; j++) begin
        blk_sum_i[i][j] = '0;
        blk_num_i[i][j] = '0;
      end
    blk_sum_i[a][b] = 7'(s);
    blk_num_i[a][b] = 3'(n);
    set_bo();
    en_i = 1'b1; first_i = f; last_i = l;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      en_i = 1'b0; first_i = 1'b0; last_i = 1'b0;
    end
  endtask

  task automatic fill(input int s, input int n, input int sb, input int nb);
    for (int i = 0; i < NE; i++)
      for (int j = 0; j < NC; j++) begin
        e.s[i][j] = s;
        e.n[i][j] = n;
      end
    for (int k = 0; k < NB; k++) begin
      e.sb[k] = BO_ON ? sb : 0;
      e.nb[k] = BO_ON ? nb : 0;
    end
  endtask

  // Called right after the closing block is driven; en_o is due next cycle.
  task automatic push_exp();
    e.cyc = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < NE; i++)
      for (int j = 0; j < NC; j++) begin
        chk({tag, "_eo_sum"}, i, j, int'(sum_blk_CTU[i][j]), 0);
        chk({tag, "_eo_num"}, i, j, int'(num_blk_CTU[i][j]), 0);
      end
    for (int k = 0; k < NB; k++) begin
      chk({tag, "_bo_sum"}, k, 0, int'(sum_blk_CTU_bo[k]), 0);
      chk({tag, "_bo_num"}, k, 0, int'(num_blk_CTU_bo[k]), 0);
    end
    chk({tag, "_en_o"}, 0, 0, int'(en_o), 0);
  endtask

  initial begin
    arst_n = 1'b1; en_i = 1'b0; first_i = 1'b0; last_i = 1'b0;
    for (int i = 0; i < NE; i++)
      for (int j = 0; j < NC; j++) begin
        blk_sum_i[i][j] = '0;
        blk_num_i[i][j] = '0;
      end
    set_bo();
    #3 arst_n = 1'b0;
    #4 check_zero("reset");
    @(negedge clk);
    @(negedge clk) arst_n = 1'b1;
    idle(2);

    // 256 blocks of +3/4: sums 768, counts 1024 saturate to 1023.
    send_u(1, 0, 3, 4);
    repeat (254) send_u(0, 0, 3, 4);
    fill(768, 1023, 1792, 1023);
    send_u(0, 1, 3, 4);
    push_exp();

    // first_i in the en_o cycle; 256 x +63 = 16128 saturates at +8191.
    send_u(1, 0, 63, 4);
    repeat (254) send_u(0, 0, 63, 4);
    fill(8191, 1023, 1792, 1023);
    send_u(0, 1, 63, 4);
    push_exp();

    // 256 x -64 = -16384 saturates at -8192.
    send_u(1, 0, -64, 4);
    repeat (254) send_u(0, 0, -64, 4);
    fill(-8192, 1023, 1792, 1023);
    send_u(0, 1, -64, 4);
    push_exp();
    idle(2);

    // Four blocks of +7 at [0][0] with two idle cycles in between.
    send_1(1, 0, 0, 0, 7, 3); idle(2);
    send_1(0, 0, 0, 0, 7, 3); idle(2);
    send_1(0, 0, 0, 0, 7, 3); idle(2);
    fill(0, 0, 28, 16);
    e.s[0][0] = 28; e.n[0][0] = 12;
    send_1(0, 1, 0, 0, 7, 3);
    push_exp();
    idle(3);
    // Non-first block after the CTU is ignored; totals stay held.
    send_u(0, 1, 9, 4);
    idle(2);
    chk("hold_sum00", 0, 0, int'(sum_blk_CTU[0][0]), 28);
    chk("hold_num00", 0, 0, int'(num_blk_CTU[0][0]), 12);
    chk("hold_sum11", 1, 1, int'(sum_blk_CTU[1][1]), 0);

    // Restart after 5 blocks: only the last 3 blocks (+2/2 each) count.
    send_u(1, 0, 1, 1);
    repeat (4) send_u(0, 0, 1, 1);
    send_u(1, 0, 2, 2);
    send_u(0, 0, 2, 2);
    fill(6, 6, 21, 12);
    send_u(0, 1, 2, 2);
    push_exp();

    // One-block CTU (first&last) in the previous en_o cycle.
    fill(0, 0, 7, 4);
    e.s[1][2] = -5; e.n[1][2] = 2;
    send_1(1, 1, 1, 2, -5, 2);
    push_exp();
    idle(3);

    // Reset mid-CTU after 10 blocks.
    send_u(1, 0, 5, 1);
    repeat (9) send_u(0, 0, 5, 1);
    @(negedge clk);
    en_i = 1'b0; first_i = 1'b0; last_i = 1'b0;
    arst_n = 1'b0;
    #1 check_zero("midreset");
    @(negedge clk) arst_n = 1'b1;
    // After release only first_i may start a CTU.
    send_u(0, 1, 5, 1);
    send_u(0, 0, 5, 1);
    idle(3);
    check_zero("postreset");

    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
    chk("scoreboard_drain", 0, 0, exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
